dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port data memory.
- Port 0 is the control unit's memory interface. Port 1 is a secondary master, such as a debug/loader or future DMA.
- Grants one transaction at a time with round-robin fairness, then drives the memory command/address/data for exactly one cycle.
- For reads, waits a fixed latency and returns the data to the winning requester only.
- Sits between the control-unit memory interface and the data memory. The tristate data bus stays at the top level.

---
 rtl/harvard_pkg.sv | 23 ++
 rtl/rr_pick2.sv | 22 ++
 rtl/dmem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harvard_pkg.sv
// Shared constants and types for the Harvard core: data/address widths,
// data-memory command encodings and the data-memory arbiter state encoding.
package harvard_pkg;

  localparam int unsigned AddrW = 8;
  localparam int unsigned DataW = 8;
  localparam int unsigned CmdW  = 8;

  localparam logic [CmdW-1:0] CMD_IDLE  = 8'h00;
  localparam logic [CmdW-1:0] CMD_READ  = 8'h01;
  localparam logic [CmdW-1:0] CMD_WRITE = 8'h02;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } arb_state_e;

  function automatic logic cmd_legal(logic [CmdW-1:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone valid wins outright; on a tie the port
// that did not win last time is chosen.
module rr_pick2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  always_comb begin
    grant_valid_o = valid0_i | valid1_i;
    grant_id_o    = 1'b0;
    unique case ({valid1_i, valid0_i})
      2'b01:   grant_id_o = 1'b0;
      2'b10:   grant_id_o = 1'b1;
      2'b11:   grant_id_o = ~last_grant_i;
      default: grant_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: grants one of two requesters at a time, issues a single
// command cycle to the memory and returns read data after a fixed latency.
module dmem_arbiter
  import harvard_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = AddrW,
  parameter int unsigned DW     = DataW
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            req0_valid_i,
  input  logic [CmdW-1:0] req0_cmd_i,
  input  logic [AW-1:0]   req0_addr_i,
  input  logic [DW-1:0]   req0_wdata_i,
  output logic            req0_ready_o,
  output logic            req0_rvalid_o,
  output logic [DW-1:0]   req0_rdata_o,

  input  logic            req1_valid_i,
  input  logic [CmdW-1:0] req1_cmd_i,
  input  logic [AW-1:0]   req1_addr_i,
  input  logic [DW-1:0]   req1_wdata_i,
  output logic            req1_ready_o,
  output logic            req1_rvalid_o,
  output logic [DW-1:0]   req1_rdata_o,

  output logic [CmdW-1:0] mem_cmd_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic [DW-1:0]   mem_rdata_i,

  output logic            err_flag_o
);

  localparam int unsigned CntW    = 4;
  localparam logic [CntW-1:0] LatInit = CntW'(RD_LAT);

  arb_state_e      state_q, state_d;
  logic            win_q, win_d;
  logic            last_q, last_d;
  logic [CmdW-1:0] cmd_q, cmd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic            rvalid0_q, rvalid0_d;
  logic            rvalid1_q, rvalid1_d;
  logic            err_q, err_d;

  logic            gnt_valid;
  logic            gnt_id;

  rr_pick2 u_pick (
    .valid0_i      (req0_valid_i),
    .valid1_i      (req1_valid_i),
    .last_grant_i  (last_q),
    .grant_valid_o (gnt_valid),
    .grant_id_o    (gnt_id)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      win_q     <= 1'b0;
      last_q    <= 1'b1;
      cmd_q     <= CMD_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          state_d = StIssue;
          win_d   = gnt_id;
          last_d  = gnt_id;
          cmd_d   = gnt_id ? req1_cmd_i   : req0_cmd_i;
          addr_d  = gnt_id ? req1_addr_i  : req0_addr_i;
          wdata_d = gnt_id ? req1_wdata_i : req0_wdata_i;
        end
      end
      StIssue: begin
        if (cmd_q == CMD_READ) begin
          state_d = StWait;
          cnt_d   = LatInit;
        end else begin
          // Illegal commands were acknowledged but never reached the memory.
          if (!cmd_legal(cmd_q)) begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (win_q) begin
            rdata1_d  = mem_rdata_i;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_rdata_i;
            rvalid0_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    mem_cmd_o    = CMD_IDLE;
    if (state_q == StIssue) begin
      req0_ready_o = ~win_q;
      req1_ready_o = win_q;
      if (cmd_legal(cmd_q)) begin
        mem_cmd_o = cmd_q;
      end
    end
  end

  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign req0_rvalid_o = rvalid0_q;
  assign req1_rvalid_o = rvalid1_q;
  assign req0_rdata_o  = rdata0_q;
  assign req1_rdata_o  = rdata1_q;
  assign err_flag_o    = err_q;

  a_one_ready: assert property (@(posedge clk_i) disable iff (rst_i)
    !(req0_ready_o && req1_ready_o));

  a_cmd_only_in_issue: assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_cmd_o != CMD_IDLE) |-> (state_q == StIssue));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (read latency 1 and 3) driven by
// directed and random requesters, checked every cycle against a schedule model.
module tb_dmem_arbiter;
  import harvard_pkg::*;

  localparam int Lat0 = 1;
  localparam int Lat1 = 3;

  typedef struct {
    logic [7:0] c;
    logic [7:0] a;
    logic [7:0] w;
  } req_t;

  typedef struct {
    int         port;
    int         cyc;
    logic [7:0] a;
    logic [7:0] w;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [2];
  logic       v    [2][2];
  logic [7:0] cmd  [2][2];
  logic [7:0] addr [2][2];
  logic [7:0] wd   [2][2];
  logic       rdy  [2][2];
  logic       rv   [2][2];
  logic [7:0] rdat [2][2];
  logic [7:0] mcmd [2];
  logic [7:0] maddr[2];
  logic [7:0] mwd  [2];
  logic [7:0] mrd  [2];
  logic       err  [2];
  logic [7:0] menv [2][256];

  assign mrd[0] = menv[0][maddr[0]];
  assign mrd[1] = menv[1][maddr[1]];

  dmem_arbiter #(.RD_LAT(Lat0), .AW(8), .DW(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]),
    .req0_valid_i(v[0][0]), .req0_cmd_i(cmd[0][0]), .req0_addr_i(addr[0][0]),
    .req0_wdata_i(wd[0][0]), .req0_ready_o(rdy[0][0]), .req0_rvalid_o(rv[0][0]),
    .req0_rdata_o(rdat[0][0]),
    .req1_valid_i(v[0][1]), .req1_cmd_i(cmd[0][1]), .req1_addr_i(addr[0][1]),
    .req1_wdata_i(wd[0][1]), .req1_ready_o(rdy[0][1]), .req1_rvalid_o(rv[0][1]),
    .req1_rdata_o(rdat[0][1]),
    .mem_cmd_o(mcmd[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwd[0]),
    .mem_rdata_i(mrd[0]), .err_flag_o(err[0])
  );

  dmem_arbiter #(.RD_LAT(Lat1), .AW(8), .DW(8)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]),
    .req0_valid_i(v[1][0]), .req0_cmd_i(cmd[1][0]), .req0_addr_i(addr[1][0]),
    .req0_wdata_i(wd[1][0]), .req0_ready_o(rdy[1][0]), .req0_rvalid_o(rv[1][0]),
    .req0_rdata_o(rdat[1][0]),
    .req1_valid_i(v[1][1]), .req1_cmd_i(cmd[1][1]), .req1_addr_i(addr[1][1]),
    .req1_wdata_i(wd[1][1]), .req1_ready_o(rdy[1][1]), .req1_rvalid_o(rv[1][1]),
    .req1_rdata_o(rdat[1][1]),
    .mem_cmd_o(mcmd[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwd[1]),
    .mem_rdata_i(mrd[1]), .err_flag_o(err[1])
  );

  // Model: each accepted transaction is a record with its accept cycle; every
  // output is derived from the cycle offset relative to that accept.
  bit         mvalid [2];
  bit         act    [2];
  bit         fresh  [2];
  bit         merr   [2];
  bit         rst_req[2];
  bit         pend   [2][2];
  bit         rand_mode;
  int         free_at[2];
  int         acc    [2];
  int         mwin   [2];
  int         mlast  [2];
  logic [7:0] tcmd   [2];
  logic [7:0] taddr  [2];
  logic [7:0] twd    [2];
  logic [7:0] mrd_m  [2][2];
  logic [7:0] mm     [2][256];
  req_t       rq     [2][2][$];
  ev_t        glog   [2][$];
  ev_t        rlog   [2][$];
  int         cyc;
  int         checks;
  int         errors;

  function automatic int lat_of(input int d);
    return (d == 0) ? Lat0 : Lat1;
  endfunction

  function automatic bit is_issue(input int d);
    return act[d] && (cyc == acc[d] + 1);
  endfunction

  function automatic bit is_wait(input int d);
    return act[d] && (tcmd[d] == CMD_READ) && (cyc >= acc[d] + 2) &&
           (cyc <= acc[d] + 1 + lat_of(d));
  endfunction

  function automatic bit is_rv(input int d);
    return act[d] && (tcmd[d] == CMD_READ) && (cyc == acc[d] + 2 + lat_of(d));
  endfunction

  function automatic bit legal(input logic [7:0] c);
    return (c == 8'h01) || (c == 8'h02);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, got, want);
    end
  endtask

  task automatic push_req(input int d, input int p, input logic [7:0] c,
                          input logic [7:0] a, input logic [7:0] w);
    req_t r;
    r.c = c;
    r.a = a;
    r.w = w;
    rq[d][p].push_back(r);
  endtask

  task automatic check_dut(input int d);
    bit         iss;
    logic [7:0] ecmd;
    ev_t        e;
    if (!mvalid[d]) return;
    iss  = is_issue(d);
    ecmd = (iss && legal(tcmd[d])) ? tcmd[d] : 8'h00;
    chk($sformatf("d%0d mem_cmd", d), 32'(mcmd[d]), 32'(ecmd));
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("d%0d ready%0d", d, p), 32'(rdy[d][p]), 32'(iss && mwin[d] == p));
      chk($sformatf("d%0d rvalid%0d", d, p), 32'(rv[d][p]), 32'(is_rv(d) && mwin[d] == p));
      chk($sformatf("d%0d rdata%0d", d, p), 32'(rdat[d][p]), 32'(mrd_m[d][p]));
    end
    chk($sformatf("d%0d err_flag", d), 32'(err[d]), 32'(merr[d]));
    if (iss) begin
      chk($sformatf("d%0d issue mem_addr", d), 32'(maddr[d]), 32'(taddr[d]));
      chk($sformatf("d%0d issue mem_wdata", d), 32'(mwd[d]), 32'(twd[d]));
    end else if (is_wait(d)) begin
      chk($sformatf("d%0d wait mem_addr", d), 32'(maddr[d]), 32'(taddr[d]));
    end else if (fresh[d]) begin
      chk($sformatf("d%0d reset mem_addr", d), 32'(maddr[d]), 32'h0);
      chk($sformatf("d%0d reset mem_wdata", d), 32'(mwd[d]), 32'h0);
    end
    for (int p = 0; p < 2; p++) begin
      if (rdy[d][p]) begin
        e.port = p; e.cyc = cyc; e.a = maddr[d]; e.w = mwd[d];
        glog[d].push_back(e);
      end
      if (rv[d][p]) begin
        e.port = p; e.cyc = cyc; e.a = rdat[d][p]; e.w = 8'h00;
        rlog[d].push_back(e);
      end
    end
    if (mcmd[d] == CMD_WRITE) menv[d][maddr[d]] = mwd[d];
  endtask

  task automatic drive_dut(input int d);
    req_t r;
    int   k;
    rst[d] = rst_req[d];
    for (int p = 0; p < 2; p++) begin
      if (pend[d][p] && is_issue(d) && mwin[d] == p) pend[d][p] = 1'b0;
      if (!pend[d][p]) begin
        if (rq[d][p].size() > 0) begin
          r = rq[d][p].pop_front();
          cmd[d][p] = r.c; addr[d][p] = r.a; wd[d][p] = r.w;
          v[d][p] = 1'b1; pend[d][p] = 1'b1;
        end else if (rand_mode && $urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, 9);
          cmd[d][p]  = (k < 4) ? 8'h01 : (k < 8) ? 8'h02 : (k == 8) ? 8'h00 : 8'($urandom);
          addr[d][p] = 8'($urandom_range(0, 15));
          wd[d][p]   = 8'($urandom);
          v[d][p] = 1'b1; pend[d][p] = 1'b1;
        end else begin
          v[d][p] = 1'b0;
          cmd[d][p] = 8'($urandom); addr[d][p] = 8'($urandom); wd[d][p] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic model_edge(input int d);
    int w;
    if (act[d] && cyc == acc[d] + 1 && tcmd[d] == CMD_WRITE) mm[d][taddr[d]] = twd[d];
    if (rst[d]) begin
      mvalid[d] = 1'b1; act[d] = 1'b0; fresh[d] = 1'b1; merr[d] = 1'b0;
      free_at[d] = cyc + 1; mlast[d] = 1;
      mrd_m[d][0] = 8'h00; mrd_m[d][1] = 8'h00;
    end else if (mvalid[d]) begin
      if (is_issue(d) && !legal(tcmd[d])) merr[d] = 1'b1;
      if (act[d] && tcmd[d] == CMD_READ && cyc == acc[d] + 1 + lat_of(d))
        mrd_m[d][mwin[d]] = mm[d][taddr[d]];
      if (cyc >= free_at[d] && (v[d][0] || v[d][1])) begin
        w = (v[d][0] && v[d][1]) ? 1 - mlast[d] : (v[d][1] ? 1 : 0);
        act[d] = 1'b1; fresh[d] = 1'b0; acc[d] = cyc; mwin[d] = w; mlast[d] = w;
        tcmd[d] = cmd[d][w]; taddr[d] = addr[d][w]; twd[d] = wd[d][w];
        free_at[d] = cyc + 2 + ((cmd[d][w] == CMD_READ) ? lat_of(d) : 0);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_dut(d);
      drive_dut(d);
      model_edge(d);
    end
    cyc++;
  endtask

  function automatic bit busy();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (rq[d][p].size() > 0 || pend[d][p]) return 1'b1;
      end
      if (act[d] && cyc <= acc[d] + 2 + lat_of(d)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL drain timeout @cycle %0d: still busy after %0d cycles, expected idle",
               cyc, budget);
    end
  endtask

  int gb;
  int n;
  int exp_p[4];
  int exp_a[4];

  initial begin
    cyc = 0; checks = 0; errors = 0; rand_mode = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rst_req[d] = 1'b1; mvalid[d] = 1'b0; act[d] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        v[d][p] = 1'b0; cmd[d][p] = 8'h00; addr[d][p] = 8'h00; wd[d][p] = 8'h00;
        pend[d][p] = 1'b0;
      end
      for (int a = 0; a < 256; a++) begin
        menv[d][a] = 8'(a) ^ 8'h3C;
        mm[d][a]   = 8'(a) ^ 8'h3C;
      end
    end

    step();
    step();
    rst_req[0] = 1'b0; rst_req[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d lit reset mem_cmd", d), 32'(mcmd[d]), 32'h0);
      chk($sformatf("d%0d lit reset rdata0", d), 32'(rdat[d][0]), 32'h0);
      chk($sformatf("d%0d lit reset err", d), 32'(err[d]), 32'h0);
    end

    // Port 0 write 0x10 <- 0xA5.
    for (int d = 0; d < 2; d++) push_req(d, 0, 8'h02, 8'h10, 8'hA5);
    drain(50);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d lit write grants", d), 32'(glog[d].size()), 32'd1);
      if (glog[d].size() >= 1) begin
        chk($sformatf("d%0d lit write port", d), 32'(glog[d][0].port), 32'd0);
        chk($sformatf("d%0d lit write addr", d), 32'(glog[d][0].a), 32'h10);
        chk($sformatf("d%0d lit write data", d), 32'(glog[d][0].w), 32'hA5);
      end
      chk($sformatf("d%0d lit port1 rdata untouched", d), 32'(rdat[d][1]), 32'h0);
    end

    // Port 1 reads it back.
    for (int d = 0; d < 2; d++) push_req(d, 1, 8'h01, 8'h10, 8'h00);
    drain(50);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d lit read rvalids", d), 32'(rlog[d].size()), 32'd1);
      if (rlog[d].size() >= 1 && glog[d].size() >= 2) begin
        chk($sformatf("d%0d lit read port", d), 32'(rlog[d][0].port), 32'd1);
        chk($sformatf("d%0d lit read data", d), 32'(rlog[d][0].a), 32'hA5);
        chk($sformatf("d%0d lit read latency", d), 32'(rlog[d][0].cyc - glog[d][1].cyc),
            (d == 0) ? 32'd2 : 32'd4);
      end
    end

    // Both ports contending: grants must alternate.
    for (int d = 0; d < 2; d++) begin
      push_req(d, 0, 8'h01, 8'h01, 8'h00); push_req(d, 0, 8'h01, 8'h01, 8'h00);
      push_req(d, 1, 8'h01, 8'h02, 8'h00); push_req(d, 1, 8'h01, 8'h02, 8'h00);
    end
    drain(100);
    exp_p = '{0, 1, 0, 1};
    exp_a = '{1, 2, 1, 2};
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d lit rr grants", d), 32'(glog[d].size()), 32'd6);
      if (glog[d].size() >= 6) begin
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("d%0d lit rr port %0d", d, i), 32'(glog[d][2+i].port), 32'(exp_p[i]));
          chk($sformatf("d%0d lit rr addr %0d", d, i), 32'(glog[d][2+i].a), 32'(exp_a[i]));
        end
      end
    end

    // Illegal command, then legal traffic; the error stays sticky.
    for (int d = 0; d < 2; d++) begin
      push_req(d, 0, 8'h07, 8'h33, 8'h44); push_req(d, 0, 8'h02, 8'h20, 8'h5A);
    end
    drain(50);
    for (int d = 0; d < 2; d++) push_req(d, 1, 8'h01, 8'h20, 8'h00);
    drain(50);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d lit err sticky", d), 32'(err[d]), 32'h1);
      chk($sformatf("d%0d lit read after illegal", d), 32'(rdat[d][1]), 32'h5A);
    end

    // Reset while both instances sit in the read wait.
    gb = glog[0].size();
    for (int d = 0; d < 2; d++) push_req(d, 0, 8'h01, 8'h10, 8'h00);
    n = 0;
    while (!(glog[0].size() > gb && cyc == acc[0] + 2) && n < 20) begin
      step();
      n++;
    end
    chk("lit reach wait state", 32'(n < 20), 32'h1);
    rst_req[0] = 1'b1; rst_req[1] = 1'b1;
    step();
    rst_req[0] = 1'b0; rst_req[1] = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d lit rst rvalid0", d), 32'(rv[d][0]), 32'h0);
      chk($sformatf("d%0d lit rst rdata0", d), 32'(rdat[d][0]), 32'h0);
      chk($sformatf("d%0d lit rst rdata1", d), 32'(rdat[d][1]), 32'h0);
      chk($sformatf("d%0d lit rst err", d), 32'(err[d]), 32'h0);
      chk($sformatf("d%0d lit rst mem_addr", d), 32'(maddr[d]), 32'h0);
    end
    gb = glog[0].size();
    for (int d = 0; d < 2; d++) begin
      push_req(d, 0, 8'h02, 8'h40, 8'h01); push_req(d, 1, 8'h02, 8'h41, 8'h02);
    end
    drain(50);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d lit post-rst grants", d), 32'(glog[d].size() - gb), 32'd2);
      if (glog[d].size() >= gb + 2) begin
        chk($sformatf("d%0d lit post-rst first", d), 32'(glog[d][gb].port), 32'd0);
        chk($sformatf("d%0d lit post-rst second", d), 32'(glog[d][gb+1].port), 32'd1);
      end
    end

    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) step();
    rand_mode = 1'b0;
    drain(200);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
